// File: rtl/vga_sync_pulses.sv
// VGA timing counters with active-region flags and line/frame start pulses.
// Each flag is decoded from the next count, so it lines up with the counter it describes.
module vga_sync_pulses #(
    parameter int H_ACTIVE = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       CLK,
    input  logic       i_RST_N,
    input  logic       i_Enable,
    output logic       o_HSync,
    output logic       o_VSync,
    output logic [9:0] o_Col_Count,
    output logic [9:0] o_Row_Count,
    output logic       o_Line_Start,
    output logic       o_Frame_Start
);

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);

    logic [9:0] col_next;
    logic [9:0] row_next;

    // The row advances only when the column wraps.
    always_comb begin
        col_next = o_Col_Count + 10'd1;
        row_next = o_Row_Count;
        if (o_Col_Count == H_LAST) begin
            col_next = '0;
            if (o_Row_Count == V_LAST) begin
                row_next = '0;
            end else begin
                row_next = o_Row_Count + 10'd1;
            end
        end
    end

    // Reset parks the counters on the last pixel so the first enabled edge lands on (0,0).
    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            o_Col_Count   <= H_LAST;
            o_Row_Count   <= V_LAST;
            o_HSync       <= 1'b0;
            o_VSync       <= 1'b0;
            o_Line_Start  <= 1'b0;
            o_Frame_Start <= 1'b0;
        end else if (i_Enable) begin
            o_Col_Count   <= col_next;
            o_Row_Count   <= row_next;
            o_HSync       <= (col_next < H_ACT);
            o_VSync       <= (row_next < V_ACT);
            o_Line_Start  <= (col_next == 10'd0);
            o_Frame_Start <= (col_next == 10'd0) && (row_next == 10'd0);
        end
    end

endmodule

// File: tb/tb_vga_sync_pulses.sv
// Bench for vga_sync_pulses: default geometry plus two reduced geometries so full frames fit
// in a short run; a position model checks every cycle, literal checks pin key points.
module tb_vga_sync_pulses;

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic       hs_a, vs_a, ls_a, fs_a;
    logic [9:0] col_a, row_a;
    logic       hs_b, vs_b, ls_b, fs_b;
    logic [9:0] col_b, row_b;
    logic       hs_c, vs_c, ls_c, fs_c;
    logic [9:0] col_c, row_c;

    int checks = 0;
    int errors = 0;
    int n = 0;
    int last_fs_b = 0;
    int last_fs_c = 0;
    int periods_b = 0;
    int periods_c = 0;

    always #5 clk = ~clk;

    vga_sync_pulses dut_a (
        .CLK(clk), .i_RST_N(rst_n), .i_Enable(en),
        .o_HSync(hs_a), .o_VSync(vs_a), .o_Col_Count(col_a), .o_Row_Count(row_a),
        .o_Line_Start(ls_a), .o_Frame_Start(fs_a)
    );

    vga_sync_pulses #(.H_ACTIVE(6), .H_TOTAL(10), .V_ACTIVE(3), .V_TOTAL(4)) dut_b (
        .CLK(clk), .i_RST_N(rst_n), .i_Enable(en),
        .o_HSync(hs_b), .o_VSync(vs_b), .o_Col_Count(col_b), .o_Row_Count(row_b),
        .o_Line_Start(ls_b), .o_Frame_Start(fs_b)
    );

    vga_sync_pulses #(.H_ACTIVE(32), .H_TOTAL(40), .V_ACTIVE(24), .V_TOTAL(30)) dut_c (
        .CLK(clk), .i_RST_N(rst_n), .i_Enable(en),
        .o_HSync(hs_c), .o_VSync(vs_c), .o_Col_Count(col_c), .o_Row_Count(row_c),
        .o_Line_Start(ls_c), .o_Frame_Start(fs_c)
    );

    // n counts enabled edges since reset release; the pixel shown is n-1 in raster order.
    function automatic logic [23:0] model(input int k, input int ht, input int ha,
                                          input int vt, input int va);
        int lin, col, row;
        logic hs, vs, ls, fs;
        lin = (k + ht * vt - 1) % (ht * vt);
        col = lin % ht;
        row = lin / ht;
        hs = (k > 0) && (col < ha);
        vs = (k > 0) && (row < va);
        ls = (k > 0) && (col == 0);
        fs = ls && (row == 0);
        return {10'(col), 10'(row), hs, vs, ls, fs};
    endfunction

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (n=%0d)", name, act, exp, n);
        end
    endtask

    task automatic check_vec(input string name, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual col=%0d row=%0d hs/vs/ls/fs=%b expected col=%0d row=%0d hs/vs/ls/fs=%b (n=%0d)",
                     name, act[23:14], act[13:4], act[3:0], exp[23:14], exp[13:4], exp[3:0], n);
        end
    endtask

    task automatic apply_stimulus(input int edges);
        repeat (edges) @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        if (rst_n && en) n = n + 1;
    end

    always @(negedge rst_n) begin
        n = 0;
        last_fs_b = 0;
        last_fs_c = 0;
    end

    // Every cycle: all three instances against the model, plus frame period between pulses.
    always @(negedge clk) begin
        if (rst_n !== 1'bx) begin
            check_vec("model_a", {col_a, row_a, hs_a, vs_a, ls_a, fs_a}, model(n, 800, 640, 525, 480));
            check_vec("model_b", {col_b, row_b, hs_b, vs_b, ls_b, fs_b}, model(n, 10, 6, 4, 3));
            check_vec("model_c", {col_c, row_c, hs_c, vs_c, ls_c, fs_c}, model(n, 40, 32, 30, 24));
            if (fs_b && n != last_fs_b) begin
                if (last_fs_b != 0) begin
                    check_output("period_b", n - last_fs_b, 40);
                    periods_b++;
                end
                last_fs_b = n;
            end
            if (fs_c && n != last_fs_c) begin
                if (last_fs_c != 0) begin
                    check_output("period_c", n - last_fs_c, 1200);
                    periods_c++;
                end
                last_fs_c = n;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        en = 1'b1;
        apply_stimulus(3);
        check_output("rst_col", int'(col_a), 799);
        check_output("rst_row", int'(row_a), 524);
        check_output("rst_flags", int'({hs_a, vs_a, ls_a, fs_a}), 0);

        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1);
        check_output("first_col", int'(col_a), 0);
        check_output("first_row", int'(row_a), 0);
        check_output("first_flags", int'({hs_a, vs_a, ls_a, fs_a}), 4'b1111);

        en = 1'b0;
        apply_stimulus(5);
        check_output("hold_col", int'(col_a), 0);
        check_output("hold_fs", int'(fs_a), 1);
        en = 1'b1;
        apply_stimulus(1);
        check_output("resume_col", int'(col_a), 1);
        check_output("resume_ls", int'(ls_a), 0);
        check_output("resume_fs", int'(fs_a), 0);

        apply_stimulus(638);
        check_output("col639_hs", int'({col_a, hs_a}), (639 << 1) | 1);
        apply_stimulus(1);
        check_output("col640_hs", int'({col_a, hs_a}), 640 << 1);
        apply_stimulus(159);
        check_output("col799_row", int'({col_a, row_a}), (799 << 10) | 0);
        apply_stimulus(1);
        check_output("wrap_col_row", int'({col_a, row_a}), (0 << 10) | 1);
        check_output("wrap_ls_fs", int'({ls_a, fs_a}), 2'b10);

        apply_stimulus(1100);
        check_output("pre_rst_pos", int'({col_a, row_a}), (300 << 10) | 2);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_col", int'(col_a), 799);
        check_output("async_row", int'(row_a), 524);
        check_output("async_flags", int'({hs_a, vs_a, ls_a, fs_a}), 0);
        apply_stimulus(2);
        check_output("rst_hold_col", int'(col_a), 799);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1);
        check_output("rerun_pos", int'({col_a, row_a}), 0);
        check_output("rerun_flags", int'({hs_a, vs_a, ls_a, fs_a}), 4'b1111);

        apply_stimulus(39);
        check_output("b_last_pos", int'({col_b, row_b}), (9 << 10) | 3);
        check_output("b_last_vs_hs", int'({hs_b, vs_b}), 0);
        apply_stimulus(1);
        check_output("b_wrap_fs", int'({col_b, row_b, fs_b}), 1);

        apply_stimulus(919);
        check_output("c_r23_pos", int'({col_c, row_c, vs_c}), (39 << 11) | (23 << 1) | 1);
        apply_stimulus(1);
        check_output("c_r24_vs", int'({col_c, row_c, vs_c, ls_c}), (24 << 2) | 2'b01);
        apply_stimulus(239);
        check_output("c_end_pos", int'({col_c, row_c}), (39 << 10) | 29);
        apply_stimulus(1);
        check_output("c_frame_fs", int'({col_c, row_c, fs_c}), 1);

        @(negedge clk);
        #1;
        check_output("periods_b_seen", int'(periods_b >= 20), 1);
        check_output("periods_c_seen", int'(periods_c >= 1), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
